multi_rate_time_base: RTL and testbench
=======================================

# multi_rate_time_base

Parametrised successor to the single-rate time-unit pulser. It divides the clock into a programmable base time unit and keeps a wide free-running time counter in those units. It also derives NCH slower channel pulses, each an integer multiple of the base unit. The block sits at the root of the FPGA time system: spike tagging uses `time_elapsed`, and the per-channel pulses drive the heartbeat, upstream-flush and tag-generator schedulers.

## Interface
- `NCLK`, 16: width of `clks_per_unit`; base unit is 1..2^NCLK-1 clocks.
- `NTIME`, 48: width of `time_elapsed`.
- `NCH`, 4: number of derived channels.
- `NDIV`, 16: width of each channel divisor.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high.
- `enable`  in  1: high = time advances; low = freeze.
- `clks_per_unit`  in  NCLK: clocks per base unit; 0 treated as 1.
- `time_set_valid`  in  1: one-cycle strobe; loads the time counter and resynchronises.
- `time_set_value`  in  NTIME: value loaded on `time_set_valid`.
- `ch_en`  in  NCH: per-channel enable.
- `ch_div`  in  NCH×NDIV: per-channel divisor in base units; 0 treated as 1.
- `unit_pulse`  out  1: one-cycle pulse per base unit.
- `time_elapsed`  out  NTIME: base units elapsed.
- `ch_pulse`  out  NCH: one-cycle pulse every `ch_div[i]` base units.

## Operation
- **Reset** (async) sets `unit_pulse`=0, `ch_pulse`=0, `time_elapsed`=0, prescaler count=1 and every channel count=1.
- **Prescaler:** on each edge with `enable`=1 and no set, compare `count` against `eff = max(clks_per_unit,1)`.
  - If `count >= eff`: `unit_pulse`<=1 and `count`<=1.
  - Otherwise: `unit_pulse`<=0 and `count`<=`count`+1.
  - The `>=` compare handles a decrease of `clks_per_unit` mid-unit: the pulse fires on the next edge, with no wrap.
- **Time counter:** increments by 1 on the same edge that sets `unit_pulse`<=1. It wraps modulo 2^NTIME to 0 with no flag.
- **Channel i:** internal tick = the prescaler fire condition (not the registered output), so channel and unit pulses are cycle-aligned.
  - On tick with `ch_en[i]`=1: if `cnt_i >= max(ch_div[i],1)`, then `ch_pulse[i]`<=1 and `cnt_i`<=1; otherwise `cnt_i`<=`cnt_i`+1.
  - `ch_pulse[i]`<=0 on every other edge.
  - `ch_en[i]`=0 forces `cnt_i`<=1 and `ch_pulse[i]`<=0. On re-enable, the first pulse comes after a full `ch_div[i]` units.
- **`enable`=0:** all counters hold; all pulse outputs go to 0 on the next edge.
- **`time_set_valid`=1:** highest priority, regardless of `enable`.
  - `time_elapsed`<=`time_set_value`.
  - Prescaler count<=1 and all `cnt_i`<=1.
  - All pulses<=0.
  - A set coinciding with a would-be fire wins: no increment, no pulse.
- **Reset mid-operation:** immediate return to the reset state; no partial pulse.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- With `clks_per_unit`=N constant and `enable` high after reset release, the first `unit_pulse` is high in the cycle after the N-th enabled edge. Pulses then repeat with period exactly N, each 1 cycle wide.
- With N=1, `unit_pulse` is held high every cycle and `time_elapsed` increments every cycle.
- `time_elapsed` is updated on the same edge that raises `unit_pulse`, so the two are consistent in the same cycle.
- `time_set_value` is visible on `time_elapsed` one cycle after the strobe edge. The next unit pulse follows N enabled edges later.
- `ch_pulse[i]` always coincides with a `unit_pulse` cycle and is never issued in any other cycle.

## Structure
- Package `time_base_pkg` holds:
  - default parameter constants `NCLK_DEF`=16, `NTIME_DEF`=48, `NCH_DEF`=4, `NDIV_DEF`=16;
  - typedef `time_t` (logic [NTIME_DEF-1:0]).
- Sub-module `unit_divider` is instantiated NCH times via generate.
  - Parameter `NDIV`.
  - Ports: `clk`, `reset`, `tick`, `clear`, `en`, `div`, `pulse`.
  - Implements the channel count/compare logic.
- The prescaler and time counter live in the top module.

## Test plan
- `clks_per_unit`=4, `enable`=1 after reset -> `unit_pulse` high every 4th cycle; `time_elapsed`=1,2,3 after the 1st/2nd/3rd pulses.
- `clks_per_unit`=0, then 1 -> `unit_pulse` high every cycle in both cases; `time_elapsed` +1 per cycle.
- `ch_div`={1,2,3,0}, `clks_per_unit`=2 -> ch0 and ch3 pulse every unit, ch1 every 2nd unit, ch2 every 3rd; every channel pulse coincides with `unit_pulse`.
- `time_set_valid` with value 2^48-2, `clks_per_unit`=3 -> `time_elapsed`=2^48-2, then 2^48-1, then 0 after two units. A strobe on a fire edge gives no pulse and no increment.
- `enable` low for 10 cycles mid-unit -> outputs 0 and `time_elapsed` frozen; on resume, the remaining clocks of the unit elapse before the next pulse.
- `clks_per_unit` changed 8->2 when count=5 -> pulse on the next edge, then period 2. Assert `reset` mid-unit -> all outputs 0 immediately.

Source files
------------

// File: rtl/time_base_pkg.sv
// Shared defaults and types for the multi-rate time base.
package time_base_pkg;
  localparam int NCLK_DEF  = 16;
  localparam int NTIME_DEF = 48;
  localparam int NCH_DEF   = 4;
  localparam int NDIV_DEF  = 16;

  typedef logic [NTIME_DEF-1:0] time_t;
endpackage

// File: rtl/unit_divider.sv
// One derived channel: counts base-unit ticks and pulses every max(div,1) ticks.
module unit_divider #(
  parameter int NDIV = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            clear,
  input  logic            en,
  input  logic [NDIV-1:0] div,
  output logic            pulse
);
  localparam logic [NDIV-1:0] ONE = NDIV'(1);

  logic [NDIV-1:0] cnt_q, cnt_d, eff_s;
  logic            pulse_q, pulse_d;

  // Next-state: clear/disable restart the count so a re-enabled channel waits a full period.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    eff_s   = (div == {NDIV{1'b0}}) ? ONE : div;
    if (clear || !en) begin
      cnt_d = ONE;
    end else if (tick) begin
      if (cnt_q >= eff_s) begin
        pulse_d = 1'b1;
        cnt_d   = ONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= ONE;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/multi_rate_time_base.sv
// Base-unit prescaler, wide elapsed-time counter and NCH derived channel pulsers.
module multi_rate_time_base
  import time_base_pkg::*;
#(
  parameter int NCLK  = NCLK_DEF,
  parameter int NTIME = NTIME_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int NDIV  = NDIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NCLK-1:0]     clks_per_unit,
  input  logic                time_set_valid,
  input  logic [NTIME-1:0]    time_set_value,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH*NDIV-1:0] ch_div,
  output logic                unit_pulse,
  output logic [NTIME-1:0]    time_elapsed,
  output logic [NCH-1:0]      ch_pulse
);
  localparam logic [NCLK-1:0]  PONE = NCLK'(1);
  localparam logic [NTIME-1:0] TONE = NTIME'(1);

  logic [NCLK-1:0]  pcnt_q, pcnt_d, eff_s;
  logic [NTIME-1:0] time_q, time_d;
  logic             unit_q, unit_d;
  logic             fire_s;

  // The >= compare lets a mid-unit shrink of clks_per_unit fire on the next edge.
  always_comb begin
    pcnt_d = pcnt_q;
    time_d = time_q;
    unit_d = 1'b0;
    eff_s  = (clks_per_unit == {NCLK{1'b0}}) ? PONE : clks_per_unit;
    fire_s = enable && !time_set_valid && (pcnt_q >= eff_s);
    if (time_set_valid) begin
      time_d = time_set_value;
      pcnt_d = PONE;
    end else if (enable) begin
      if (fire_s) begin
        unit_d = 1'b1;
        pcnt_d = PONE;
        time_d = time_q + TONE;
      end else begin
        pcnt_d = pcnt_q + PONE;
      end
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Prescaler and time counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= PONE;
      time_q <= {NTIME{1'b0}};
      unit_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      time_q <= time_d;
      unit_q <= unit_d;
    end
  end

  assign unit_pulse   = unit_q;
  assign time_elapsed = time_q;

  // Channels tick on the combinational fire so they align with unit_pulse.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    unit_divider #(.NDIV(NDIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .tick  (fire_s),
      .clear (time_set_valid),
      .en    (ch_en[i]),
      .div   (ch_div[i*NDIV +: NDIV]),
      .pulse (ch_pulse[i])
    );
  end
endmodule

// File: tb/tb_multi_rate_time_base.sv
// Directed self-checking bench for multi_rate_time_base.
module tb_multi_rate_time_base;
  import time_base_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] clks_per_unit = 16'd4;
  logic        time_set_valid = 1'b0;
  time_t       time_set_value = '0;
  logic [3:0]  ch_en = 4'h0;
  logic [63:0] ch_div = 64'd0;
  logic        unit_pulse;
  time_t       time_elapsed;
  logic [3:0]  ch_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  localparam time_t TMAX_M1 = 48'hFFFF_FFFF_FFFE;

  multi_rate_time_base dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .clks_per_unit  (clks_per_unit),
    .time_set_valid (time_set_valid),
    .time_set_value (time_set_value),
    .ch_en          (ch_en),
    .ch_div         (ch_div),
    .unit_pulse     (unit_pulse),
    .time_elapsed   (time_elapsed),
    .ch_pulse       (ch_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic u, input time_t t, input logic [3:0] c);
    check({tag, "_unit"}, 64'(unit_pulse), 64'(u));
    check({tag, "_time"}, 64'(time_elapsed), 64'(t));
    check({tag, "_ch"}, 64'(ch_pulse), 64'(c));
  endtask

  initial begin
    logic [3:0] e;
    int u;

    // Reset state
    @(negedge clk);
    check_all("reset", 1'b0, '0, 4'h0);

    // N=4: pulse every 4th edge, time advances with it
    enable = 1'b1;
    clks_per_unit = 16'd4;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick_n(1);
      check("n4_unit", 64'(unit_pulse), 64'(k % 4 == 0));
      check("n4_time", 64'(time_elapsed), 64'(k / 4));
    end

    // N=0 then N=1: pulse every cycle
    clks_per_unit = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      tick_n(1);
      check("n0_unit", 64'(unit_pulse), 64'd1);
      check("n0_time", 64'(time_elapsed), 64'(3 + k));
    end
    clks_per_unit = 16'd1;
    for (int k = 1; k <= 4; k++) begin
      tick_n(1);
      check("n1_unit", 64'(unit_pulse), 64'd1);
      check("n1_time", 64'(time_elapsed), 64'(7 + k));
    end
    enable = 1'b0;
    tick_n(1);
    check_all("dis_n1", 1'b0, 48'd11, 4'h0);
    enable = 1'b1;

    // Channels: div {ch3..ch0} = {0,3,2,1}, N=2
    clks_per_unit = 16'd2;
    ch_div = {16'd0, 16'd3, 16'd2, 16'd1};
    ch_en = 4'hF;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      tick_n(1);
      u = k / 2;
      e = (k % 2 == 0) ? {1'b1, (u % 3 == 0), (u % 2 == 0), 1'b1} : 4'h0;
      check("ch_unit", 64'(unit_pulse), 64'(k % 2 == 0));
      check("ch_pulse", 64'(ch_pulse), 64'(e));
    end
    // ch1 disabled while its count is 2, re-enabled after unit 9
    ch_en = 4'b1101;
    tick_n(2);
    check("chdis_u8", 64'(ch_pulse), 64'h9);
    tick_n(2);
    check("chdis_u9", 64'(ch_pulse), 64'hD);
    ch_en = 4'hF;
    tick_n(1);
    check("chre_odd", 64'(ch_pulse), 64'h0);
    tick_n(1);
    check("chre_u10", 64'(ch_pulse), 64'h9);
    tick_n(2);
    check("chre_u11", 64'(ch_pulse), 64'hB);
    ch_en = 4'h0;

    // Time set near wrap, N=3
    clks_per_unit = 16'd3;
    do_reset();
    time_set_valid = 1'b1;
    time_set_value = TMAX_M1;
    tick_n(1);
    time_set_valid = 1'b0;
    check_all("set", 1'b0, TMAX_M1, 4'h0);
    tick_n(2);
    check("set_a2_unit", 64'(unit_pulse), 64'd0);
    tick_n(1);
    check_all("set_a3", 1'b1, 48'hFFFF_FFFF_FFFF, 4'h0);
    tick_n(3);
    check_all("wrap", 1'b1, 48'd0, 4'h0);
    // Strobe on a would-be fire edge: no pulse, no increment
    tick_n(2);
    time_set_valid = 1'b1;
    time_set_value = 48'd100;
    tick_n(1);
    time_set_valid = 1'b0;
    check_all("set_on_fire", 1'b0, 48'd100, 4'h0);
    tick_n(2);
    check("after_set_c2", 64'(unit_pulse), 64'd0);
    tick_n(1);
    check_all("after_set_c3", 1'b1, 48'd101, 4'h0);

    // Enable low mid-unit, N=4
    clks_per_unit = 16'd4;
    do_reset();
    tick_n(4);
    check_all("pre_pause", 1'b1, 48'd1, 4'h0);
    tick_n(2);
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick_n(1);
      check("pause_unit", 64'(unit_pulse), 64'd0);
    end
    check("pause_time", 64'(time_elapsed), 64'd1);
    enable = 1'b1;
    tick_n(1);
    check("resume_r1", 64'(unit_pulse), 64'd0);
    tick_n(1);
    check_all("resume_r2", 1'b1, 48'd2, 4'h0);

    // clks_per_unit 8 -> 2 when count is 5
    clks_per_unit = 16'd8;
    do_reset();
    tick_n(4);
    check("c8_mid", 64'(unit_pulse), 64'd0);
    clks_per_unit = 16'd2;
    tick_n(1);
    check_all("shrink_fire", 1'b1, 48'd1, 4'h0);
    tick_n(1);
    check("shrink_gap", 64'(unit_pulse), 64'd0);
    tick_n(1);
    check_all("shrink_p2", 1'b1, 48'd2, 4'h0);

    // Async reset while a pulse is high
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 48'd0, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
